// File: rtl/duty_button_ctrl.sv
// Two-button synchronise/debounce/lockout front end emitting one-cycle increase/decrease pulses for pwm_gen.
// Build with DUTY_BTN_REPEAT_EN defined to add hold-to-repeat pulses.
module duty_button_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_PERIOD   = 8,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_btn,
    input  logic dec_btn,
    output logic increase_duty,
    output logic decrease_duty,
    output logic inc_level,
    output logic dec_level
);
    typedef enum logic {ST_IDLE = 1'b0, ST_PRESSED = 1'b1} state_e;

    localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
    localparam longint unsigned  CNT_SPAN  = 64'd1 << CNT_W;

    if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) >= CNT_SPAN ||
        64'(REPEAT_DELAY) >= CNT_SPAN || 64'(REPEAT_PERIOD) >= CNT_SPAN) begin : g_bad_cfg
        $error("duty_button_ctrl: illegal parameter set");
    end

    // Channel 0 is the increase button, channel 1 the decrease button.
    logic [1:0]       btn_raw;
    logic [1:0]       meta_q, sync_q;
    logic [1:0]       level_q, level_d;
    logic [1:0]       pulse_q, pulse_d;
    logic [1:0]       locked;
    logic [CNT_W-1:0] deb_cnt_q [2];
    logic [CNT_W-1:0] deb_cnt_d [2];
    state_e           state_q [2];
    state_e           state_d [2];

`ifdef DUTY_BTN_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LIMIT  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_LIMIT = CNT_W'(REPEAT_PERIOD);

    logic [CNT_W-1:0] hold_q   [2];
    logic [CNT_W-1:0] hold_d   [2];
    logic [CNT_W-1:0] hold_inc [2];
    logic [1:0]       rep_q, rep_d;

    assign hold_inc[0] = hold_q[0] + CNT_W'(1);
    assign hold_inc[1] = hold_q[1] + CNT_W'(1);
`endif

    assign btn_raw   = {dec_btn, inc_btn};
    assign locked[0] = level_q[1] | level_d[1];
    assign locked[1] = level_q[0] | level_d[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= '0;
            sync_q  <= '0;
            level_q <= '0;
            pulse_q <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= '0;
                state_q[i]   <= ST_IDLE;
`ifdef DUTY_BTN_REPEAT_EN
                hold_q[i]    <= '0;
`endif
            end
`ifdef DUTY_BTN_REPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            meta_q  <= btn_raw;
            sync_q  <= meta_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
                state_q[i]   <= state_d[i];
`ifdef DUTY_BTN_REPEAT_EN
                hold_q[i]    <= hold_d[i];
`endif
            end
`ifdef DUTY_BTN_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    // A mismatch must survive DEBOUNCE_CYCLES+1 consecutive samples, which places
    // the level change on edge 2+DEBOUNCE_CYCLES after the raw input settles.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            level_d[i]   = level_q[i];
            deb_cnt_d[i] = '0;
            if (sync_q[i] != level_q[i]) begin
                if (deb_cnt_q[i] >= DEB_LIMIT) begin
                    level_d[i] = sync_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            pulse_d[i] = 1'b0;
`ifdef DUTY_BTN_REPEAT_EN
            hold_d[i]  = '0;
            rep_d[i]   = 1'b0;
`endif
            case (state_q[i])
                ST_IDLE: begin
                    if (level_d[i]) begin
                        state_d[i] = ST_PRESSED;
                        pulse_d[i] = ~locked[i];
                    end
                end
                ST_PRESSED: begin
                    if (!level_d[i]) begin
                        state_d[i] = ST_IDLE;
                    end
`ifdef DUTY_BTN_REPEAT_EN
                    else if (!locked[i]) begin
                        // Lockout restarts the full initial delay once it lifts.
                        if (hold_inc[i] == (rep_q[i] ? PERIOD_LIMIT : DELAY_LIMIT)) begin
                            pulse_d[i] = 1'b1;
                            rep_d[i]   = 1'b1;
                        end else begin
                            hold_d[i]  = hold_inc[i];
                            rep_d[i]   = rep_q[i];
                        end
                    end
`endif
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    assign increase_duty = pulse_q[0];
    assign decrease_duty = pulse_q[1];
    assign inc_level     = level_q[0];
    assign dec_level     = level_q[1];

endmodule

// File: tb/tb_duty_button_ctrl.sv
// Bench for duty_button_ctrl: directed scenarios plus randomized button traffic against a history-based model.
module tb_duty_button_ctrl;
    localparam int DEB = 4;
    localparam int DLY = 16;
    localparam int PER = 8;

    logic clk = 1'b0;
    logic rst;
    logic inc_btn;
    logic dec_btn;
    logic increase_duty, decrease_duty, inc_level, dec_level;

    int checks = 0;
    int errors = 0;

    duty_button_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (DLY),
        .REPEAT_PERIOD  (PER),
        .CNT_W          (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inc_btn      (inc_btn),
        .dec_btn      (dec_btn),
        .increase_duty(increase_duty),
        .decrease_duty(decrease_duty),
        .inc_level    (inc_level),
        .dec_level    (dec_level)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples per edge since reset; a level flips when the
    // last DEB+1 synchronised samples (raw delayed two edges) all disagree with it.
    bit samp_i[$];
    bit samp_d[$];
    bit m_lvl[2];
    bit m_pulse[2];
    int m_anchor[2];
    int m_n;

    function automatic bit samp_at(int ch, int idx);
        if (idx < 0) return 1'b0;
        return (ch == 0) ? samp_i[idx] : samp_d[idx];
    endfunction

    task automatic model_reset();
        samp_i.delete();
        samp_d.delete();
        m_lvl    = '{1'b0, 1'b0};
        m_pulse  = '{1'b0, 1'b0};
        m_anchor = '{0, 0};
        m_n      = 0;
    endtask

    task automatic model_edge(input bit raw_i, input bit raw_d);
        bit new_lvl[2];
        bit flip;
        bit lock;
        int d;
        samp_i.push_back(raw_i);
        samp_d.push_back(raw_d);
        for (int ch = 0; ch < 2; ch++) begin
            flip = 1'b1;
            for (int k = 0; k <= DEB; k++)
                if (samp_at(ch, m_n - 2 - k) == m_lvl[ch]) flip = 1'b0;
            new_lvl[ch] = flip ? ~m_lvl[ch] : m_lvl[ch];
        end
        for (int ch = 0; ch < 2; ch++) begin
            lock = m_lvl[1-ch] | new_lvl[1-ch];
            m_pulse[ch] = 1'b0;
            if (!m_lvl[ch] && new_lvl[ch]) begin
                m_pulse[ch]  = !lock;
                m_anchor[ch] = m_n;
            end
`ifdef DUTY_BTN_REPEAT_EN
            else if (m_lvl[ch] && new_lvl[ch]) begin
                if (lock) begin
                    m_anchor[ch] = m_n;
                end else begin
                    d = m_n - m_anchor[ch];
                    if (d == DLY || (d > DLY && (d - DLY) % PER == 0)) m_pulse[ch] = 1'b1;
                end
            end
`endif
        end
        m_lvl = new_lvl;
        m_n++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inc_btn = 1'b1;
        dec_btn = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if ({increase_duty, decrease_duty, inc_level, dec_level} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: outputs=%b expected 0000", {increase_duty, decrease_duty, inc_level, dec_level});
        end
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({increase_duty, decrease_duty, inc_level, dec_level} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: outputs=%b expected 0000", {increase_duty, decrease_duty, inc_level, dec_level});
        end
    endtask

    task automatic test_bounce();
        do_reset();
        inc_btn = 1'b1;
        for (int e = 0; e < 25; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (increase_duty !== 1'b0 || inc_level !== 1'b0 || decrease_duty !== 1'b0) begin
                errors++;
                $display("FAIL bounce: edge %0d inc_pulse=%b inc_level=%b dec_pulse=%b expected 0 0 0",
                         e, increase_duty, inc_level, decrease_duty);
            end
            if (e == 2) inc_btn = 1'b0;
        end
    endtask

    task automatic test_clean_press();
        do_reset();
        inc_btn = 1'b1;
        for (int e = 0; e < 26; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (increase_duty !== (e == 6) || inc_level !== (e >= 6 && e < 16) || decrease_duty !== 1'b0) begin
                errors++;
                $display("FAIL clean_press: edge %0d pulse=%b level=%b dec=%b expected %b %b 0",
                         e, increase_duty, inc_level, decrease_duty, (e == 6), (e >= 6 && e < 16));
            end
            if (e == 9) inc_btn = 1'b0;
        end
    endtask

    task automatic test_repeat();
        int n_pulses = 0;
        int exp_pulses;
        bit exp_p;
`ifdef DUTY_BTN_REPEAT_EN
        exp_pulses = 4;
`else
        exp_pulses = 1;
`endif
        do_reset();
        dec_btn = 1'b1;
        for (int e = 0; e < 52; e++) begin
            @(posedge clk);
            #1;
`ifdef DUTY_BTN_REPEAT_EN
            exp_p = (e == 6 || e == 22 || e == 30 || e == 38);
`else
            exp_p = (e == 6);
`endif
            if (decrease_duty === 1'b1) n_pulses++;
            checks++;
            if (decrease_duty !== exp_p || dec_level !== (e >= 6 && e < 42) || increase_duty !== 1'b0) begin
                errors++;
                $display("FAIL hold_repeat: edge %0d dec_pulse=%b dec_level=%b inc=%b expected %b %b 0",
                         e, decrease_duty, dec_level, increase_duty, exp_p, (e >= 6 && e < 42));
            end
            if (e == 35) dec_btn = 1'b0;
        end
        checks++;
        if (n_pulses != exp_pulses) begin
            errors++;
            $display("FAIL hold_pulse_count: got %0d expected %0d", n_pulses, exp_pulses);
        end
    endtask

    task automatic test_simultaneous();
        bit exp_l;
        do_reset();
        inc_btn = 1'b1;
        dec_btn = 1'b1;
        for (int e = 0; e < 56; e++) begin
            @(posedge clk);
            #1;
            exp_l = (e >= 6 && e < 46);
            checks++;
            if (increase_duty !== 1'b0 || decrease_duty !== 1'b0 || inc_level !== exp_l || dec_level !== exp_l) begin
                errors++;
                $display("FAIL simultaneous: edge %0d pulses=%b%b levels=%b%b expected 00 %b%b",
                         e, increase_duty, decrease_duty, inc_level, dec_level, exp_l, exp_l);
            end
            if (e == 39) begin
                inc_btn = 1'b0;
                dec_btn = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        inc_btn = 1'b1;
        for (int e = 0; e < 9; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (increase_duty !== (e == 6)) begin
                errors++;
                $display("FAIL pre_reset_press: edge %0d pulse=%b expected %b", e, increase_duty, (e == 6));
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({increase_duty, decrease_duty, inc_level, dec_level} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: outputs=%b expected 0000", {increase_duty, decrease_duty, inc_level, dec_level});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e < 14; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (increase_duty !== (e == 6) || inc_level !== (e >= 6)) begin
                errors++;
                $display("FAIL post_reset_press: edge %0d pulse=%b level=%b expected %b %b",
                         e, increase_duty, inc_level, (e == 6), (e >= 6));
            end
        end
        inc_btn = 1'b0;
    endtask

    task automatic test_random();
        int seg_left[2];
        bit val[2];
        do_reset();
        model_reset();
        seg_left = '{0, 0};
        val = '{1'b0, 1'b0};
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (seg_left[ch] == 0) begin
                    val[ch] = 1'($urandom_range(0, 1));
                    seg_left[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5))
                                                              : int'($urandom_range(6, 60));
                end
                seg_left[ch]--;
            end
            inc_btn = val[0];
            dec_btn = val[1];
            @(posedge clk);
            model_edge(inc_btn, dec_btn);
            #1;
            checks++;
            if (increase_duty !== m_pulse[0] || decrease_duty !== m_pulse[1] ||
                inc_level !== m_lvl[0] || dec_level !== m_lvl[1]) begin
                errors++;
                $display("FAIL random: edge %0d pulses=%b%b levels=%b%b expected %b%b %b%b",
                         cyc, increase_duty, decrease_duty, inc_level, dec_level,
                         m_pulse[0], m_pulse[1], m_lvl[0], m_lvl[1]);
            end
            checks++;
            if ((increase_duty & decrease_duty) !== 1'b0) begin
                errors++;
                $display("FAIL exclusive: edge %0d both pulses=%b%b expected not 11", cyc, increase_duty, decrease_duty);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        test_reset();
        test_bounce();
        test_clean_press();
        test_repeat();
        test_simultaneous();
        test_reset_mid_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
